// File: rtl/otter_iobus_arbiter_pkg.sv
// Shared types for the OTTER IO bus arbiter: FSM states, master IDs and the
// command word captured on a grant.
package otter_iobus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

  localparam logic MASTER0 = 1'b0;
  localparam logic MASTER1 = 1'b1;

  // Wide enough for the largest legal read latency (7).
  localparam int LAT_W = 3;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] data;
  } iobus_cmd_t;

endpackage

// File: rtl/otter_iobus_arbiter_if.sv
// Bundle of both master request ports and the peripheral IO bus.
// The arbiter takes the slave view; the masters/peripheral side takes the master view.
interface otter_iobus_arbiter_if;

  logic        i_m0_req;
  logic        i_m0_we;
  logic [3:0]  i_m0_sel;
  logic [31:0] i_m0_addr;
  logic [31:0] i_m0_w_data;
  logic        o_m0_gnt;
  logic        o_m0_rvalid;
  logic [31:0] o_m0_r_data;

  logic        i_m1_req;
  logic        i_m1_we;
  logic [3:0]  i_m1_sel;
  logic [31:0] i_m1_addr;
  logic [31:0] i_m1_w_data;
  logic        o_m1_gnt;
  logic        o_m1_rvalid;
  logic [31:0] o_m1_r_data;

  logic        o_iobus_re;
  logic        o_iobus_we;
  logic [3:0]  o_iobus_sel;
  logic [31:0] o_iobus_addr;
  logic [31:0] o_iobus_data;
  logic [31:0] i_iobus_data;

  modport slave (
    input  i_m0_req, i_m0_we, i_m0_sel, i_m0_addr, i_m0_w_data,
    output o_m0_gnt, o_m0_rvalid, o_m0_r_data,
    input  i_m1_req, i_m1_we, i_m1_sel, i_m1_addr, i_m1_w_data,
    output o_m1_gnt, o_m1_rvalid, o_m1_r_data,
    output o_iobus_re, o_iobus_we, o_iobus_sel, o_iobus_addr, o_iobus_data,
    input  i_iobus_data
  );

  modport master (
    output i_m0_req, i_m0_we, i_m0_sel, i_m0_addr, i_m0_w_data,
    input  o_m0_gnt, o_m0_rvalid, o_m0_r_data,
    output i_m1_req, i_m1_we, i_m1_sel, i_m1_addr, i_m1_w_data,
    input  o_m1_gnt, o_m1_rvalid, o_m1_r_data,
    input  o_iobus_re, o_iobus_we, o_iobus_sel, o_iobus_addr, o_iobus_data,
    output i_iobus_data
  );

endinterface

// File: rtl/otter_iobus_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to
// the master that was not granted last.
module otter_rr_pick2
  import otter_iobus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last == MASTER0) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/otter_iobus_arbiter.sv
// Two-master round-robin arbiter and read sequencer for the OTTER IO bus.
// One transaction in flight; read data is sampled RD_LATENCY cycles after issue.
module otter_iobus_arbiter
  import otter_iobus_arbiter_pkg::*;
#(
  parameter int RD_LATENCY = 0
) (
  input logic                  i_clk,
  input logic                  i_rst,
  otter_iobus_arbiter_if.slave bus
);

  arb_state_t       state;
  logic             owner;
  logic             last_owner;
  iobus_cmd_t       cmd;
  iobus_cmd_t       pick_cmd;
  logic             re_q;
  logic             we_q;
  logic [LAT_W-1:0] lat_cnt;
  logic [1:0]       req;
  logic [1:0]       pick;
  logic             grant;
  logic             capture;
  logic             m0_rvalid_q;
  logic             m1_rvalid_q;
  logic [31:0]      m0_rdata_q;
  logic [31:0]      m1_rdata_q;

  assign req = {bus.i_m1_req, bus.i_m0_req};

  otter_rr_pick2 u_pick (
    .req  (req),
    .last (last_owner),
    .gnt  (pick)
  );

  // Reset outranks a grant that would otherwise be offered this cycle.
  assign grant        = (state == ST_IDLE) && !i_rst && (pick != 2'b00);
  assign bus.o_m0_gnt = grant & pick[0];
  assign bus.o_m1_gnt = grant & pick[1];

  always_comb begin
    pick_cmd = '{we: bus.i_m0_we, sel: bus.i_m0_sel, addr: bus.i_m0_addr, data: bus.i_m0_w_data};
    if (pick[1]) begin
      pick_cmd = '{we: bus.i_m1_we, sel: bus.i_m1_sel, addr: bus.i_m1_addr, data: bus.i_m1_w_data};
    end
  end

  // A zero-latency peripheral is sampled in the issue cycle itself.
  assign capture = ((state == ST_ISSUE) && !cmd.we && (RD_LATENCY == 0)) ||
                   ((state == ST_WAIT) && (lat_cnt == LAT_W'(1)));

  assign bus.o_iobus_re   = re_q;
  assign bus.o_iobus_we   = we_q;
  assign bus.o_iobus_sel  = cmd.sel;
  assign bus.o_iobus_addr = cmd.addr;
  assign bus.o_iobus_data = cmd.data;
  assign bus.o_m0_rvalid  = m0_rvalid_q;
  assign bus.o_m1_rvalid  = m1_rvalid_q;
  assign bus.o_m0_r_data  = m0_rdata_q;
  assign bus.o_m1_r_data  = m1_rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      owner       <= MASTER0;
      last_owner  <= MASTER1;
      cmd         <= '0;
      re_q        <= 1'b0;
      we_q        <= 1'b0;
      lat_cnt     <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      m0_rvalid_q <= capture && (owner == MASTER0);
      m1_rvalid_q <= capture && (owner == MASTER1);
      if (capture && (owner == MASTER0)) m0_rdata_q <= bus.i_iobus_data;
      if (capture && (owner == MASTER1)) m1_rdata_q <= bus.i_iobus_data;
      re_q <= 1'b0;
      we_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant) begin
            owner      <= pick[1] ? MASTER1 : MASTER0;
            last_owner <= pick[1] ? MASTER1 : MASTER0;
            cmd        <= pick_cmd;
            re_q       <= !pick_cmd.we;
            we_q       <= pick_cmd.we;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (cmd.we || (RD_LATENCY == 0)) begin
            cmd   <= '0;
            state <= ST_IDLE;
          end else begin
            lat_cnt <= LAT_W'(RD_LATENCY);
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (lat_cnt == LAT_W'(1)) begin
            cmd   <= '0;
            state <= ST_IDLE;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_otter_iobus_arbiter.sv
// Bench for otter_iobus_arbiter: three lanes at read latencies 0, 3 and 5, each
// checked every cycle against a transaction-level model of the arbitration rules.
module tb_otter_iobus_arbiter;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst     [3];
  logic        req     [3][2];
  logic        we_in   [3][2];
  logic [3:0]  sel_in  [3][2];
  logic [31:0] addr_in [3][2];
  logic [31:0] wd_in   [3][2];
  logic [31:0] pdata   [3];
  logic        gnt     [3][2];
  logic        rv      [3][2];
  logic [31:0] rd      [3][2];
  logic        io_re   [3];
  logic        io_we   [3];
  logic [3:0]  io_sel  [3];
  logic [31:0] io_addr [3];
  logic [31:0] io_data [3];

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int LAT = (g == 0) ? 0 : ((g == 1) ? 3 : 5);
    otter_iobus_arbiter_if bus ();
    otter_iobus_arbiter #(.RD_LATENCY(LAT)) dut (
      .i_clk (clk),
      .i_rst (rst[g]),
      .bus   (bus)
    );
    assign bus.i_m0_req     = req[g][0];
    assign bus.i_m0_we      = we_in[g][0];
    assign bus.i_m0_sel     = sel_in[g][0];
    assign bus.i_m0_addr    = addr_in[g][0];
    assign bus.i_m0_w_data  = wd_in[g][0];
    assign bus.i_m1_req     = req[g][1];
    assign bus.i_m1_we      = we_in[g][1];
    assign bus.i_m1_sel     = sel_in[g][1];
    assign bus.i_m1_addr    = addr_in[g][1];
    assign bus.i_m1_w_data  = wd_in[g][1];
    assign bus.i_iobus_data = pdata[g];
    assign gnt[g][0]  = bus.o_m0_gnt;
    assign gnt[g][1]  = bus.o_m1_gnt;
    assign rv[g][0]   = bus.o_m0_rvalid;
    assign rv[g][1]   = bus.o_m1_rvalid;
    assign rd[g][0]   = bus.o_m0_r_data;
    assign rd[g][1]   = bus.o_m1_r_data;
    assign io_re[g]   = bus.o_iobus_re;
    assign io_we[g]   = bus.o_iobus_we;
    assign io_sel[g]  = bus.o_iobus_sel;
    assign io_addr[g] = bus.o_iobus_addr;
    assign io_data[g] = bus.o_iobus_data;
  end

  // Model state: pending master commands, arbiter availability and the in-flight transaction.
  bit          pend_v    [3][2];
  logic        pend_we   [3][2];
  logic [3:0]  pend_sel  [3][2];
  logic [31:0] pend_addr [3][2];
  logic [31:0] pend_data [3][2];
  int          free_at   [3];
  int          ptr       [3];
  bit          known     [3];
  bit          tx_v      [3];
  int          tx_issue  [3];
  int          tx_own    [3];
  logic        tx_we     [3];
  logic [3:0]  tx_sel    [3];
  logic [31:0] tx_addr   [3];
  logic [31:0] tx_data   [3];
  logic [31:0] m_rd      [3][2];
  int          rv_at     [3][2];
  int          cyc;
  int          total;
  int          bad;
  bit          magic_en;

  function automatic int lat_of(int d);
    return (d == 0) ? 0 : ((d == 1) ? 3 : 5);
  endfunction

  task automatic chk(string tag, int d, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s lane%0d cycle %0d observed=%h expected=%h", tag, d, cyc, obs, exp);
    end
  endtask

  task automatic post(int d, int m, logic we, logic [3:0] sel, logic [31:0] a, logic [31:0] w);
    pend_v[d][m]    = 1'b1;
    pend_we[d][m]   = we;
    pend_sel[d][m]  = sel;
    pend_addr[d][m] = a;
    pend_data[d][m] = w;
  endtask

  task automatic post_all(int m, logic we, logic [3:0] sel, logic [31:0] a, logic [31:0] w);
    for (int d = 0; d < 3; d++) post(d, m, we, sel, a, w);
  endtask

  task automatic check_lane(int d, int win);
    bit act;
    bit is_issue;
    act      = tx_v[d] && (cyc >= tx_issue[d]) &&
               (cyc <= tx_issue[d] + (tx_we[d] ? 0 : lat_of(d)));
    is_issue = act && (cyc == tx_issue[d]);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("gnt%0d", m), d, 32'(gnt[d][m]), 32'(win == m));
      chk($sformatf("rvalid%0d", m), d, 32'(rv[d][m]), 32'(rv_at[d][m] == cyc));
      chk($sformatf("r_data%0d", m), d, rd[d][m], m_rd[d][m]);
    end
    chk("iobus_re", d, 32'(io_re[d]), 32'(is_issue && !tx_we[d]));
    chk("iobus_we", d, 32'(io_we[d]), 32'(is_issue && tx_we[d]));
    chk("iobus_sel", d, 32'(io_sel[d]), act ? 32'(tx_sel[d]) : 32'd0);
    chk("iobus_addr", d, io_addr[d], act ? tx_addr[d] : 32'd0);
    chk("iobus_data", d, io_data[d], act ? tx_data[d] : 32'd0);
  endtask

  task automatic advance(int d, int win);
    if (rst[d]) begin
      known[d]   = 1'b1;
      tx_v[d]    = 1'b0;
      free_at[d] = cyc + 1;
      ptr[d]     = 1;
      for (int m = 0; m < 2; m++) begin
        m_rd[d][m]  = '0;
        rv_at[d][m] = -1;
      end
    end else begin
      if (tx_v[d] && !tx_we[d] && (cyc == tx_issue[d] + lat_of(d))) begin
        m_rd[d][tx_own[d]]  = pdata[d];
        rv_at[d][tx_own[d]] = cyc + 1;
      end
      if (win >= 0) begin
        tx_v[d]      = 1'b1;
        tx_issue[d]  = cyc + 1;
        tx_own[d]    = win;
        tx_we[d]     = pend_we[d][win];
        tx_sel[d]    = pend_sel[d][win];
        tx_addr[d]   = pend_addr[d][win];
        tx_data[d]   = pend_data[d][win];
        free_at[d]   = cyc + 2 + (pend_we[d][win] ? 0 : lat_of(d));
        ptr[d]       = win;
        pend_v[d][win] = 1'b0;
      end
    end
  endtask

  task automatic run_cycle();
    int win;
    for (int d = 0; d < 3; d++) begin
      for (int m = 0; m < 2; m++) begin
        req[d][m]     = pend_v[d][m];
        we_in[d][m]   = pend_we[d][m];
        sel_in[d][m]  = pend_sel[d][m];
        addr_in[d][m] = pend_addr[d][m];
        wd_in[d][m]   = pend_data[d][m];
      end
      pdata[d] = $urandom();
      if (magic_en && tx_v[d] && !tx_we[d] && (cyc == tx_issue[d] + lat_of(d)))
        pdata[d] = 32'h1234_5678;
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      win = -1;
      if (!rst[d] && (cyc >= free_at[d])) begin
        if (pend_v[d][0] && pend_v[d][1]) win = 1 - ptr[d];
        else if (pend_v[d][0])            win = 0;
        else if (pend_v[d][1])            win = 1;
      end
      if (known[d]) check_lane(d, win);
      advance(d, win);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(int n);
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1;
      pend_v[d][0] = 1'b0;
      pend_v[d][1] = 1'b0;
    end
    repeat (n) run_cycle();
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
  endtask

  initial begin
    int n4 [3];
    total    = 0;
    bad      = 0;
    cyc      = 0;
    magic_en = 1'b0;
    for (int d = 0; d < 3; d++) begin
      known[d] = 1'b0;
      tx_v[d]  = 1'b0;
      for (int m = 0; m < 2; m++) begin
        pend_v[d][m]    = 1'b0;
        pend_we[d][m]   = 1'b0;
        pend_sel[d][m]  = '0;
        pend_addr[d][m] = '0;
        pend_data[d][m] = '0;
        m_rd[d][m]      = '0;
        rv_at[d][m]     = -1;
      end
    end

    // Single write from the hart.
    do_reset(2);
    post_all(0, 1'b1, 4'hF, 32'h0000_1000, 32'hDEAD_BEEF);
    repeat (4) run_cycle();

    // Master 1 read; the magic word is only on the bus in the sampling cycle.
    magic_en = 1'b1;
    post_all(1, 1'b0, 4'hF, 32'h0000_2004, 32'h0);
    repeat (9) run_cycle();
    magic_en = 1'b0;
    for (int d = 0; d < 3; d++) chk("read_word", d, rd[d][1], 32'h1234_5678);

    // Both masters requesting continuously from reset.
    do_reset(1);
    repeat (16) begin
      for (int d = 0; d < 3; d++)
        for (int m = 0; m < 2; m++)
          if (!pend_v[d][m])
            post(d, m, 1'($urandom_range(1)), 4'($urandom), $urandom(), $urandom());
      run_cycle();
    end

    // Back-to-back reads from the hart.
    do_reset(1);
    for (int d = 0; d < 3; d++) n4[d] = 0;
    repeat (12) begin
      for (int d = 0; d < 3; d++)
        if (!pend_v[d][0] && n4[d] < 4) begin
          post(d, 0, 1'b0, 4'h3, 32'h3000 + 32'(4 * n4[d]), 32'h0);
          n4[d]++;
        end
      run_cycle();
    end
    repeat (6) run_cycle();

    // Reset two cycles after a read issue, then a tie.
    do_reset(1);
    post_all(0, 1'b0, 4'hF, 32'h0000_4000, 32'h0);
    repeat (3) run_cycle();
    for (int d = 0; d < 3; d++) rst[d] = 1'b1;
    run_cycle();
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    post_all(0, 1'b1, 4'h1, 32'h0000_4100, 32'hAAAA_0000);
    post_all(1, 1'b1, 4'h2, 32'h0000_4200, 32'hBBBB_0000);
    repeat (8) run_cycle();

    // Master 1 raises its request for one busy cycle and withdraws it.
    do_reset(1);
    post_all(0, 1'b0, 4'h0, 32'h0000_5000, 32'h0);
    run_cycle();
    post_all(1, 1'b1, 4'hF, 32'h0000_6000, 32'h5555_5555);
    run_cycle();
    for (int d = 0; d < 3; d++) pend_v[d][1] = 1'b0;
    repeat (8) run_cycle();

    // Random traffic with occasional resets.
    repeat (1500) begin
      for (int d = 0; d < 3; d++) begin
        for (int m = 0; m < 2; m++)
          if (!pend_v[d][m] && $urandom_range(2) == 0)
            post(d, m, 1'($urandom_range(1)), 4'($urandom), $urandom(), $urandom());
        rst[d] = ($urandom_range(149) == 0);
      end
      run_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
